// File: rtl/colparity_pkg.sv
// Shared constants, lane indexing and FSM state type for the theta column-parity block.
package colparity_pkg;

    localparam int ROWS    = 5;
    localparam int COLS    = 5;
    localparam int SLICE_W = ROWS * COLS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    // Lane (x,y) lives at bit 24-(5*y+x) of a slice.
    function automatic logic [4:0] bit_idx(input int x, input int y);
        return 5'(SLICE_W - 1 - (COLS * y + x));
    endfunction

endpackage

// File: rtl/colparity_theta_apply_if.sv
// Handshake bundle for colparity_theta_apply; par_dbg exists only with COLPARITY_DBG_EN.
interface colparity_theta_apply_if #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 64
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_slice;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_slice;
    logic [IDX_W-1:0] out_index;
    logic             busy;
    logic             done;
`ifdef COLPARITY_DBG_EN
    logic [4:0]       par_dbg;
`endif

    modport master (
        output start, in_valid, in_slice, out_ready,
        input  in_ready, out_valid, out_slice, out_index, busy, done
`ifdef COLPARITY_DBG_EN
        , input par_dbg
`endif
    );

    modport slave (
        input  start, in_valid, in_slice, out_ready,
        output in_ready, out_valid, out_slice, out_index, busy, done
`ifdef COLPARITY_DBG_EN
        , output par_dbg
`endif
    );

endinterface

// File: rtl/slice_colparity.sv
// Combinational 5-bit column parity of one 5x5 slice.
module slice_colparity
    import colparity_pkg::*;
#(
    parameter int WIDTH = SLICE_W
) (
    input  logic [WIDTH-1:0] slice,
    output logic [COLS-1:0]  par
);

    always_comb begin
        par = '0;
        for (int x = 0; x < COLS; x++) begin
            for (int y = 0; y < ROWS; y++) begin
                par[3'(x)] = par[3'(x)] ^ slice[bit_idx(x, y)];
            end
        end
    end

endmodule

// File: rtl/colparity_theta_apply.sv
// Buffers a full frame of slices, then emits each slice with the theta column-parity mix.
// Optional COLPARITY_DBG_EN adds par_dbg showing the column parity of the emitted slice.
module colparity_theta_apply
    import colparity_pkg::*;
#(
    parameter int WIDTH = SLICE_W,
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    colparity_theta_apply_if.slave bus
);

    localparam int               IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

    state_e           state;
    logic [IDX_W-1:0] load_cnt;
    logic [IDX_W-1:0] idx_p1;
    logic [WIDTH-1:0] slice_p1;
    logic             vld_p1;
    logic             in_rdy;
    logic             busy_r;
    logic             done_r;

    logic [IDX_W-1:0] rd_idx;
    logic [COLS-1:0]  in_par;
    logic [COLS-1:0]  prev_par;
    logic [WIDTH-1:0] emit_nxt;
    logic             accept;

    logic [WIDTH-1:0] mem_slice [DEPTH];
    logic [COLS-1:0]  mem_par   [DEPTH];

    function automatic logic [WIDTH-1:0] theta(input logic [WIDTH-1:0] s,
                                               input logic [COLS-1:0]  c,
                                               input logic [COLS-1:0]  cp);
        logic [WIDTH-1:0] r;
        logic             d;
        r = s;
        for (int x = 0; x < COLS; x++) begin
            d = c[3'((x + 4) % COLS)] ^ cp[3'((x + 1) % COLS)];
            for (int y = 0; y < ROWS; y++) begin
                r[bit_idx(x, y)] = s[bit_idx(x, y)] ^ d;
            end
        end
        return r;
    endfunction

    slice_colparity #(.WIDTH(WIDTH)) u_par (
        .slice (bus.in_slice),
        .par   (in_par)
    );

    assign accept = in_rdy && bus.in_valid;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_slice[load_cnt] <= bus.in_slice;
            mem_par[load_cnt]   <= in_par;
        end
    end

    // Next slice to present; z=0 is prepared on the last load beat, so its
    // wrap-around neighbour parity comes straight from the incoming slice.
    always_comb begin
        rd_idx   = idx_p1 + 1'b1;
        prev_par = mem_par[idx_p1];
        if (state == ST_LOAD) begin
            rd_idx   = '0;
            prev_par = in_par;
        end
        emit_nxt = theta(mem_slice[rd_idx], mem_par[rd_idx], prev_par);
    end

    // ---- control / output register stage ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            load_cnt <= '0;
            idx_p1   <= '0;
            slice_p1 <= '0;
            vld_p1   <= 1'b0;
            in_rdy   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_LOAD;
                        in_rdy   <= 1'b1;
                        busy_r   <= 1'b1;
                        load_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (load_cnt == LAST) begin
                            load_cnt <= '0;
                            state    <= ST_EMIT;
                            in_rdy   <= 1'b0;
                            vld_p1   <= 1'b1;
                            idx_p1   <= '0;
                            slice_p1 <= emit_nxt;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (vld_p1 && bus.out_ready) begin
                        if (idx_p1 == LAST) begin
                            state    <= ST_IDLE;
                            vld_p1   <= 1'b0;
                            idx_p1   <= '0;
                            slice_p1 <= '0;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            idx_p1   <= idx_p1 + 1'b1;
                            slice_p1 <= emit_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_p1;
    assign bus.out_slice = slice_p1;
    assign bus.out_index = idx_p1;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

`ifdef COLPARITY_DBG_EN
    assign bus.par_dbg = vld_p1 ? mem_par[idx_p1] : '0;
`endif

endmodule

// File: tb/tb_colparity_theta_apply.sv
// Directed scoreboard bench for colparity_theta_apply (5x5 slices, 64-slice frames).
module tb_colparity_theta_apply;

    localparam int W = 25;
    localparam int D = 64;

    typedef struct packed {
        logic [5:0]  idx;
        logic [24:0] dat;
    } exp_t;

    logic clk;
    logic rst;

    colparity_theta_apply_if #(.WIDTH(W), .DEPTH(D)) bus ();

    colparity_theta_apply #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_fail;
    logic [24:0] frame [D];
    logic [24:0] cap   [D];
    exp_t        q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] col_par(input logic [24:0] s);
        logic [4:0] p;
        p = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                p[x] = p[x] ^ s[24 - (5 * y + x)];
        return p;
    endfunction

    // Expected output for slice z, walking output bits rather than lanes.
    function automatic logic [24:0] model_out(input int z);
        logic [4:0]  c;
        logic [4:0]  cp;
        logic [24:0] r;
        int          x;
        c  = col_par(frame[z]);
        cp = col_par(frame[(z + D - 1) % D]);
        for (int b = 0; b < 25; b++) begin
            x    = (24 - b) % 5;
            r[b] = frame[z][b] ^ c[(x + 4) % 5] ^ cp[(x + 1) % 5];
        end
        return r;
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int z = 0; z < D; z++) begin
            e.idx = 6'(z);
            e.dat = model_out(z);
            q.push_back(e);
        end
    endtask

    task automatic load_slices(input int count);
        int  sent;
        int  cyc;
        bit  acc;
        sent = 0;
        cyc  = 0;
        while (sent < count && cyc < 1000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_slice = frame[sent];
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("load_budget", 32'(sent), 32'(count));
    endtask

    task automatic run_frame(input bit bp, input bit poke_start);
        int   got;
        int   cyc;
        int   dones;
        int   hold;
        bit   rdy;
        exp_t e;
        push_expected();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("load_in_ready", 32'(bus.in_ready), 32'd1);
        check("load_busy", 32'(bus.busy), 32'd1);
        load_slices(D);
        check("emit_first_valid", 32'(bus.out_valid), 32'd1);
        check("emit_in_ready", 32'(bus.in_ready), 32'd0);
        got   = 0;
        cyc   = 0;
        dones = 0;
        hold  = 0;
        while (got < D && cyc < 2000) begin
            rdy = 1'b1;
            if (bp && bus.out_index == 6'd5 && hold < 3) begin
                rdy = 1'b0;
                hold++;
            end
            bus.start     = poke_start && (got == 10);
            bus.out_ready = rdy;
            check("emit_valid", 32'(bus.out_valid), 32'd1);
            if (bus.out_valid && q.size() > 0) begin
                e = q[0];
                check("out_index", 32'(bus.out_index), 32'(e.idx));
                check("out_slice", 32'(bus.out_slice), 32'(e.dat));
                if (rdy) begin
                    cap[bus.out_index] = bus.out_slice;
                    void'(q.pop_front());
                    got++;
                end
            end
            @(posedge clk);
            #1;
            if (bus.done) dones++;
            cyc++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("emit_count", 32'(got), 32'(D));
        if (bp) check("bp_hold_cycles", 32'(hold), 32'd3);
        check("done_after_last", 32'(bus.done), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        if (bus.done) dones++;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("done_pulses", 32'(dones), 32'd1);
        check("queue_empty", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic fill_random();
        for (int z = 0; z < D; z++) frame[z] = 25'($urandom);
    endtask

    task automatic fill_zero();
        for (int z = 0; z < D; z++) frame[z] = '0;
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_slice  = '0;
        bus.out_ready = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_slice", 32'(bus.out_slice), 32'd0);
        check("rst_out_index", 32'(bus.out_index), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // all-zero frame
        fill_zero();
        run_frame(1'b0, 1'b0);
        check("zero_last", 32'(cap[63]), 32'd0);

        // single lane in slice 0
        fill_zero();
        frame[0] = 25'h1000000;
        run_frame(1'b0, 1'b0);
        check("lane_z0", 32'(cap[0]), 32'h1842108);
        check("lane_z1", 32'(cap[1]), 32'h0108421);
        check("lane_z2", 32'(cap[2]), 32'd0);
        check("lane_z63", 32'(cap[63]), 32'd0);

        // single lane in slice 63 exercises the wrap-around neighbour
        fill_zero();
        frame[63] = 25'h1000000;
        run_frame(1'b0, 1'b0);
        check("wrap_z63", 32'(cap[63]), 32'h1842108);
        check("wrap_z0", 32'(cap[0]), 32'h0108421);
        check("wrap_z62", 32'(cap[62]), 32'd0);

        // random frame with a 3-cycle stall at z=5
        fill_random();
        run_frame(1'b1, 1'b0);

        // reset in the middle of a load aborts the frame
        fill_random();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        load_slices(10);
        #2 rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        #2 rst = 1'b1;
        fill_random();
        run_frame(1'b0, 1'b0);

        // start pulsed while emitting is ignored
        fill_random();
        run_frame(1'b0, 1'b1);
        check("post_poke_idle_ready", 32'(bus.in_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
